// File: rtl/disp_timing_if.sv
// -----------------------------------------------------------------------------
// disp_timing_if
//   Bundle between the display timing generator and its consumers (colour-bar
//   and pixel generators on the CRT/LCD path).
//
//   EN          run request, driven by the consumer/controller
//   TX_HS       horizontal sync, level set by HS_POL of the generator
//   TX_VS       vertical sync, level set by VS_POL of the generator
//   TX_DE       data enable, high on an active pixel
//   TX_CLK      one-CLK-wide pixel enable
//   H_POS       horizontal position of the pixel currently presented
//   V_POS       vertical position of the pixel currently presented
//   FRAME_START high for the pixel period that presents (0,0)
//   BUSY        high while frames are being generated
//
//   master : the timing generator (drives timing, samples EN)
//   slave  : the consumer (drives EN, samples timing)
// -----------------------------------------------------------------------------
interface disp_timing_if;
  logic        EN;
  logic        TX_HS;
  logic        TX_VS;
  logic        TX_DE;
  logic        TX_CLK;
  logic [11:0] H_POS;
  logic [11:0] V_POS;
  logic        FRAME_START;
  logic        BUSY;

  modport master (
    input  EN,
    output TX_HS, TX_VS, TX_DE, TX_CLK, H_POS, V_POS, FRAME_START, BUSY
  );

  modport slave (
    output EN,
    input  TX_HS, TX_VS, TX_DE, TX_CLK, H_POS, V_POS, FRAME_START, BUSY
  );
endinterface

// File: rtl/disp_timing.sv
// -----------------------------------------------------------------------------
// disp_timing
//   Display timing generator. CLK is divided into a one-cycle pixel enable
//   (TX_CLK); horizontal and vertical counters advance on that enable and the
//   sync / data-enable / frame-start outputs are decoded from the new counter
//   values on the same edge, so every output describes the position shown
//   with it. An EN/BUSY handshake makes sure only whole frames are emitted:
//   dropping EN lets the running frame finish before the generator idles.
//
// Ports
//   CLK    system clock
//   RST_N  synchronous, active-low reset
//   bus    disp_timing_if.master: EN in; TX_HS, TX_VS, TX_DE, TX_CLK, H_POS,
//          V_POS, FRAME_START, BUSY out
// -----------------------------------------------------------------------------
module disp_timing #(
  parameter int CKE_DIV  = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic          CLK,
  input  logic          RST_N,
  disp_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [4:0]  DIV_LAST = 5'(CKE_DIV - 1);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  div_q;
  logic [4:0]  div_d;
  logic        cke_q;
  logic [11:0] h_q;
  logic [11:0] v_q;
  logic [11:0] h_d;
  logic [11:0] v_d;
  logic        h_wrap;
  logic        frame_end;
  logic        de_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;
  logic        busy_q;

  function automatic logic dec_de(input logic [11:0] h, input logic [11:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  function automatic logic dec_hs(input logic [11:0] h);
    return ((h >= HS_BEG) && (h <= HS_END)) ? HS_POL : ~HS_POL;
  endfunction

  function automatic logic dec_vs(input logic [11:0] v);
    return ((v >= VS_BEG) && (v <= VS_END)) ? VS_POL : ~VS_POL;
  endfunction

  // Next counter values, used on every cke edge in RUN/STOP.
  always_comb begin
    div_d     = (div_q == DIV_LAST) ? 5'd0 : div_q + 5'd1;
    h_wrap    = (h_q == H_LAST);
    frame_end = h_wrap && (v_q == V_LAST);
    h_d       = h_wrap ? 12'd0 : h_q + 12'd1;
    v_d       = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div_q   <= 5'd0;
      cke_q   <= 1'b0;
      state_q <= S_IDLE;
      h_q     <= 12'd0;
      v_q     <= 12'd0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // The divider free-runs in every state; cke_q is high for the cycle
      // after the divider reaches its last count, giving a CKE_DIV period.
      div_q <= div_d;
      cke_q <= (div_q == DIV_LAST);

      if (cke_q) begin
        case (state_q)
          S_IDLE: begin
            if (bus.EN) begin
              // Start edge presents (0,0) directly.
              state_q <= S_RUN;
              h_q     <= 12'd0;
              v_q     <= 12'd0;
              de_q    <= dec_de(12'd0, 12'd0);
              hs_q    <= dec_hs(12'd0);
              vs_q    <= dec_vs(12'd0);
              fs_q    <= 1'b1;
              busy_q  <= 1'b1;
            end
          end

          S_RUN, S_STOP: begin
            if ((state_q == S_STOP) && frame_end && !bus.EN) begin
              // Frame finished after a stop request: back to idle values
              // instead of presenting a new (0,0).
              state_q <= S_IDLE;
              h_q     <= 12'd0;
              v_q     <= 12'd0;
              de_q    <= 1'b0;
              hs_q    <= ~HS_POL;
              vs_q    <= ~VS_POL;
              fs_q    <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              // EN only selects RUN vs STOP; the timing never stalls, so a
              // re-raised EN during STOP leaves the cadence untouched.
              state_q <= bus.EN ? S_RUN : S_STOP;
              h_q     <= h_d;
              v_q     <= v_d;
              de_q    <= dec_de(h_d, v_d);
              hs_q    <= dec_hs(h_d);
              vs_q    <= dec_vs(v_d);
              fs_q    <= frame_end;
              busy_q  <= 1'b1;
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.TX_CLK      = cke_q;
  assign bus.TX_HS       = hs_q;
  assign bus.TX_VS       = vs_q;
  assign bus.TX_DE       = de_q;
  assign bus.H_POS       = h_q;
  assign bus.V_POS       = v_q;
  assign bus.FRAME_START = fs_q;
  assign bus.BUSY        = busy_q;

endmodule

// File: doc/disp_timing.md
Name: disp_timing

Overview:
- Display timing generator; the source end of the TX_HS/TX_VS/TX_DE/TX_CLK interface consumed by the colorbar/pixel generators on the CRT/LCD path.
- Divides CLK into a one-cycle pixel enable (TX_CLK) and runs horizontal and vertical counters on it.
- Emits sync, data-enable, pixel position and frame-start markers.
- A start/stop handshake (EN/BUSY) guarantees only whole frames are emitted.

Parameters:
CKE_DIV, 1, CLK cycles per pixel (1..16); 1 means TX_CLK is high every cycle once out of reset
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, hsync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vsync width, lines
V_BP, 33, vertical back porch, lines
HS_POL, 0, hsync active level (0 = active-low #hsync)
VS_POL, 0, vsync active level (0 = active-low #vsync)

Ports:
CLK  in  1  system clock
RST_N  in  1  reset; one clock, reset is synchronous and active-low
EN  in  1  run request
TX_HS  out  1  hsync, level per HS_POL
TX_VS  out  1  vsync, level per VS_POL
TX_DE  out  1  data enable / #blank, high = active pixel
TX_CLK  out  1  pixel clock enable, one CLK cycle wide
H_POS  out  12  horizontal counter value of the current pixel
V_POS  out  12  vertical counter value of the current pixel
FRAME_START  out  1  high for one pixel period when position (0,0) is presented
BUSY  out  1  high while generating frames (RUN or STOP)

Behaviour:
- Legal parameters: every field ≥1. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP ≤ 4096. V_TOTAL (same sum over V fields) ≤ 4096.
- Reset (RST_N=0 at a CLK edge): divider=0, TX_CLK=0, H_POS=V_POS=0, TX_DE=0, TX_HS=~HS_POL, TX_VS=~VS_POL, FRAME_START=0, BUSY=0, state IDLE.
- Reset asserted mid-frame: all outputs take their reset values on that edge; no frame completion.
- Divider: counts 0..CKE_DIV-1 continuously in every state. TX_CLK is registered and equals 1 in the cycle after the divider reaches CKE_DIV-1. Internal cke = TX_CLK.
  - First TX_CLK pulse occurs CKE_DIV cycles after reset release.
  - Period is exactly CKE_DIV CLK cycles.
- All other outputs update only on CLK edges where cke=1, so they are stable for a whole pixel period and change on the same edge that TX_CLK is sampled high.
- Line layout (H_POS): active 0..H_ACTIVE-1, then FP, then SYNC, then BP; wraps to 0 after H_TOTAL-1.
- Frame layout (V_POS): same ordering over lines. V_POS increments only on the H wrap edge and wraps to 0 after V_TOTAL-1.
- Output decode: outputs are decoded from the new counter value on the same edge, so TX_DE/TX_HS/TX_VS/FRAME_START always describe the H_POS/V_POS shown with them (zero relative latency).
  - TX_DE = (H_POS < H_ACTIVE) & (V_POS < V_ACTIVE).
  - TX_HS = HS_POL while H_POS is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; ~HS_POL otherwise.
  - TX_VS = VS_POL while V_POS is in the matching vertical sync range. It changes only together with the H_POS=0 transition.
  - FRAME_START = (H_POS==0) & (V_POS==0) in RUN.
- State machine (advances on cke edges only):
  - IDLE: counters held at 0; TX_DE=0; syncs inactive; BUSY=0. Exit to RUN on the first cke edge with EN=1; that edge presents (0,0) with FRAME_START=1 and BUSY=1.
  - RUN: free-running counters. EN=0 at any cke edge → STOP; counting continues uninterrupted.
  - STOP: counting continues. EN=1 → RUN with no disturbance to timing.
    - At the cke edge where the counters would wrap from (H_TOTAL-1, V_TOTAL-1): go to IDLE, outputs return to IDLE values, BUSY=0. No new FRAME_START is produced.
- EN is sampled only on cke edges; EN pulses shorter than a pixel period between cke edges are ignored.

Test Plan:
Use bench parameters CKE_DIV=2, H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), polarities 0.
1. Reset then EN=0 for 40 CLKs -> TX_CLK pulses every 2nd CLK starting CLK 2; TX_HS=TX_VS=1, TX_DE=0, BUSY=0, H_POS=V_POS=0.
2. EN=1 held -> FRAME_START on the first cke with (0,0). TX_DE high for H_POS 0..7 on lines 0..3. TX_HS low for H_POS 10..12. TX_VS low for lines 5..6, changing only with H_POS=0. FRAME_START repeats every 128 pixels (256 CLKs).
3. Drop EN at (H_POS=3, V_POS=2) -> frame completes through (15,7). Next cke: H_POS=V_POS=0, BUSY=0, no FRAME_START, TX_DE stays 0.
4. Drop EN at (5,1), re-raise at (9,6) -> BUSY never falls; FRAME_START after (15,7); sync cadence unchanged.
5. RST_N=0 for one cke-aligned CLK at (6,3) mid-frame -> same edge: TX_DE=0, syncs inactive, positions 0, BUSY=0. With EN still 1, restart at (0,0) on the first cke after release.
6. CKE_DIV=1 rerun of scenario 2 -> TX_CLK continuously 1; one frame spans exactly 128 CLKs.
